parity_stream_checker: RTL and testbench

//   Multi-lane parity checker on a valid/ready stream: per-lane parity check, one register slice.

---
 rtl/parity_pkg.sv | 23 ++
 rtl/parity_encoder.sv | 21 ++
 rtl/parity_stream_checker.sv | 154 +++++++++++++++
 tb/tb_parity_stream_checker.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/parity_pkg.sv
// Shared parity helpers for the parity stream checker.
//   parity_of  : XOR-reduction of a word of up to PARITY_MAX_WIDTH bits
//   num_lanes  : number of parity lanes in a data word
//   PARITY_EVEN / PARITY_ODD : parity sense selectors
package parity_pkg;

  localparam int unsigned PARITY_MAX_WIDTH = 64;

  localparam bit PARITY_EVEN = 1'b0;
  localparam bit PARITY_ODD  = 1'b1;

  // Lanes per word; callers guarantee data_width is a multiple of lane_width.
  function automatic int unsigned num_lanes(input int unsigned data_width,
                                            input int unsigned lane_width);
    return data_width / lane_width;
  endfunction

  // XOR of all bits; narrower words are zero-extended by the caller.
  function automatic logic parity_of(input logic [PARITY_MAX_WIDTH-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/parity_encoder.sv
// Parity encoder: produces the code bit that makes XOR(data, code) equal to
// the selected parity sense (0 for even, 1 for odd).
//   data      in  DATA_WIDTH  word to encode
//   parity_c  out 1           combinational code bit
module parity_encoder
  import parity_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter bit          ODD_PARITY = PARITY_EVEN
) (
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  parity_c
);

  if (DATA_WIDTH > PARITY_MAX_WIDTH) begin : g_width_check
    $error("parity_encoder: DATA_WIDTH exceeds PARITY_MAX_WIDTH");
  end

  assign parity_c = parity_of(PARITY_MAX_WIDTH'(data)) ^ ODD_PARITY;

endmodule

// File: rtl/parity_stream_checker.sv
// Multi-lane parity checker on a valid/ready stream with a single register
// slice. Data passes through unchanged, tagged with per-lane and any-lane
// error flags; sticky status (and optionally an error counter) records
// erroneous beats at accept time.
// Optional feature macro: PARITY_STREAM_CHECKER_COUNTER_EN adds error_count.
// Ports:
//   clock, resetn                     clock (rising edge), async active-low reset
//   in_valid/in_ready/in_data/in_code input beat and its per-lane parity bits
//   out_valid/out_ready/out_data      registered output beat
//   out_lane_error/out_error          registered per-lane / any-lane mismatch
//   clear                             pulse clearing sticky status and counter
//   sticky_error/sticky_lane_mask     accumulated error status
//   error_count                       saturating erroneous-beat count (macro only)
module parity_stream_checker
  import parity_pkg::*;
#(
  parameter int unsigned  DATA_WIDTH    = 32,
  parameter int unsigned  LANE_WIDTH    = 8,
  parameter bit           ODD_PARITY    = PARITY_EVEN,
  parameter int unsigned  COUNTER_WIDTH = 16,
  localparam int unsigned NUM_LANES     = num_lanes(DATA_WIDTH, LANE_WIDTH)
) (
  input  logic                     clock,
  input  logic                     resetn,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [DATA_WIDTH-1:0]    in_data,
  input  logic [NUM_LANES-1:0]     in_code,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_WIDTH-1:0]    out_data,
  output logic [NUM_LANES-1:0]     out_lane_error,
  output logic                     out_error,
  input  logic                     clear,
  output logic                     sticky_error,
  output logic [NUM_LANES-1:0]     sticky_lane_mask
`ifdef PARITY_STREAM_CHECKER_COUNTER_EN
  ,
  output logic [COUNTER_WIDTH-1:0] error_count
`endif
);

  if ((DATA_WIDTH % LANE_WIDTH) != 0) begin : g_lane_check
    $error("parity_stream_checker: DATA_WIDTH must be a multiple of LANE_WIDTH");
  end
  if (COUNTER_WIDTH == 0) begin : g_counter_check
    $error("parity_stream_checker: COUNTER_WIDTH must be nonzero");
  end

  logic [NUM_LANES-1:0] exp_code_c;
  logic [NUM_LANES-1:0] lane_err_c;
  logic                 accept_c;
  logic                 beat_err_c;

  // One encoder per lane regenerates the expected code bit.
  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    parity_encoder #(
      .DATA_WIDTH (LANE_WIDTH),
      .ODD_PARITY (ODD_PARITY)
    ) u_enc (
      .data     (in_data[g*LANE_WIDTH +: LANE_WIDTH]),
      .parity_c (exp_code_c[g])
    );
  end

  logic                  out_valid_q,        out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q,         out_data_d;
  logic [NUM_LANES-1:0]  out_lane_error_q,   out_lane_error_d;
  logic                  out_error_q,        out_error_d;
  logic                  sticky_error_q,     sticky_error_d;
  logic [NUM_LANES-1:0]  sticky_lane_mask_q, sticky_lane_mask_d;

  assign lane_err_c = exp_code_c ^ in_code;
  assign beat_err_c = |lane_err_c;
  // Slice can take a beat whenever it is empty or being drained this cycle.
  assign in_ready   = !out_valid_q || out_ready;
  assign accept_c   = in_valid && in_ready;

  // Output register slice.
  always_comb begin
    out_valid_d      = out_valid_q;
    out_data_d       = out_data_q;
    out_lane_error_d = out_lane_error_q;
    out_error_d      = out_error_q;
    if (accept_c) begin
      out_valid_d      = 1'b1;
      out_data_d       = in_data;
      out_lane_error_d = lane_err_c;
      out_error_d      = beat_err_c;
    end else if (out_ready) begin
      out_valid_d      = 1'b0;
    end
  end

  // Sticky status: clear applies first so a same-cycle erroneous beat survives.
  always_comb begin
    sticky_error_d     = clear ? 1'b0 : sticky_error_q;
    sticky_lane_mask_d = clear ? '0   : sticky_lane_mask_q;
    if (accept_c && beat_err_c) begin
      sticky_error_d     = 1'b1;
      sticky_lane_mask_d = sticky_lane_mask_d | lane_err_c;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      out_valid_q        <= 1'b0;
      out_data_q         <= '0;
      out_lane_error_q   <= '0;
      out_error_q        <= 1'b0;
      sticky_error_q     <= 1'b0;
      sticky_lane_mask_q <= '0;
    end else begin
      out_valid_q        <= out_valid_d;
      out_data_q         <= out_data_d;
      out_lane_error_q   <= out_lane_error_d;
      out_error_q        <= out_error_d;
      sticky_error_q     <= sticky_error_d;
      sticky_lane_mask_q <= sticky_lane_mask_d;
    end
  end

  assign out_valid        = out_valid_q;
  assign out_data         = out_data_q;
  assign out_lane_error   = out_lane_error_q;
  assign out_error        = out_error_q;
  assign sticky_error     = sticky_error_q;
  assign sticky_lane_mask = sticky_lane_mask_q;

`ifdef PARITY_STREAM_CHECKER_COUNTER_EN
  localparam logic [COUNTER_WIDTH-1:0] COUNT_MAX = '1;

  logic [COUNTER_WIDTH-1:0] error_count_q, error_count_d;

  // Saturating count of erroneous beats, one per beat regardless of lanes.
  always_comb begin
    error_count_d = clear ? '0 : error_count_q;
    if (accept_c && beat_err_c && (error_count_d != COUNT_MAX)) begin
      error_count_d = error_count_d + COUNTER_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      error_count_q <= '0;
    end else begin
      error_count_q <= error_count_d;
    end
  end

  assign error_count = error_count_q;
`endif

endmodule

// File: tb/tb_parity_stream_checker.sv
// Directed self-checking bench for parity_stream_checker (even-parity main
// instance with a 4-bit counter, plus an odd-parity instance).
module tb_parity_stream_checker;

  logic        clock = 1'b0;
  logic        resetn;
  logic        in_valid, in_ready, out_valid, out_ready, out_error, clear, sticky_error;
  logic [31:0] in_data, out_data;
  logic [3:0]  in_code, out_lane_error, sticky_lane_mask;
  logic [3:0]  error_count;

  logic        o_in_valid, o_in_ready, o_out_valid, o_out_ready, o_out_error, o_clear, o_sticky_error;
  logic [31:0] o_in_data, o_out_data;
  logic [3:0]  o_in_code, o_out_lane_error, o_sticky_lane_mask;
  logic [15:0] o_error_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  parity_stream_checker #(
    .DATA_WIDTH(32), .LANE_WIDTH(8), .ODD_PARITY(1'b0), .COUNTER_WIDTH(4)
  ) dut (
    .clock(clock), .resetn(resetn),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_code(in_code),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_lane_error(out_lane_error), .out_error(out_error),
    .clear(clear), .sticky_error(sticky_error), .sticky_lane_mask(sticky_lane_mask)
`ifdef PARITY_STREAM_CHECKER_COUNTER_EN
    , .error_count(error_count)
`endif
  );

  parity_stream_checker #(
    .DATA_WIDTH(32), .LANE_WIDTH(8), .ODD_PARITY(1'b1), .COUNTER_WIDTH(16)
  ) dut_odd (
    .clock(clock), .resetn(resetn),
    .in_valid(o_in_valid), .in_ready(o_in_ready), .in_data(o_in_data), .in_code(o_in_code),
    .out_valid(o_out_valid), .out_ready(o_out_ready), .out_data(o_out_data),
    .out_lane_error(o_out_lane_error), .out_error(o_out_error),
    .clear(o_clear), .sticky_error(o_sticky_error), .sticky_lane_mask(o_sticky_lane_mask)
`ifdef PARITY_STREAM_CHECKER_COUNTER_EN
    , .error_count(o_error_count)
`endif
  );

`ifndef PARITY_STREAM_CHECKER_COUNTER_EN
  initial begin
    error_count   = '0;
    o_error_count = '0;
  end
`endif

  // Advance to just after the next rising edge.
  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    resetn = 1'b0; in_valid = 1'b0; in_data = '0; in_code = '0; out_ready = 1'b0; clear = 1'b0;
    o_in_valid = 1'b0; o_in_data = '0; o_in_code = '0; o_out_ready = 1'b0; o_clear = 1'b0;
    repeat (2) tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %0h expected 0", out_valid); end
    n_cmp++; if (out_data !== 32'h0) begin n_bad++; $display("FAIL reset_out_data: got %0h expected 0", out_data); end
    n_cmp++; if (out_lane_error !== 4'h0) begin n_bad++; $display("FAIL reset_lane_error: got %0h expected 0", out_lane_error); end
    n_cmp++; if (sticky_error !== 1'b0 || sticky_lane_mask !== 4'h0) begin n_bad++; $display("FAIL reset_sticky: got %0h/%0h expected 0/0", sticky_error, sticky_lane_mask); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %0h expected 1", in_ready); end
    n_cmp++; if (o_out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_odd_out_valid: got %0h expected 0", o_out_valid); end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back;
    int accepts = 0;
    int outs    = 0;
    int errs    = 0;
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h0; in_code = 4'b0000;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) accepts++;
      tick();
      if (out_valid) outs++;
      if (out_error) errs++;
    end
    in_valid = 1'b0;
    n_cmp++; if (accepts !== 100) begin n_bad++; $display("FAIL b2b_accepts: got %0d expected 100", accepts); end
    n_cmp++; if (outs !== 100) begin n_bad++; $display("FAIL b2b_outputs: got %0d expected 100", outs); end
    n_cmp++; if (errs !== 0) begin n_bad++; $display("FAIL b2b_out_error: got %0d expected 0", errs); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL b2b_drain: got %0h expected 0", out_valid); end
    n_cmp++; if (sticky_error !== 1'b0) begin n_bad++; $display("FAIL b2b_sticky: got %0h expected 0", sticky_error); end
  endtask

  task automatic test_single_beat;
    // lanes 04,03,02,01 have parity 1,0,1,1; code 1110 mismatches lanes 0 and 1.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h01020304; in_code = 4'b1110;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL beat_valid: got %0h expected 1", out_valid); end
    n_cmp++; if (out_data !== 32'h01020304) begin n_bad++; $display("FAIL beat_data: got %0h expected 01020304", out_data); end
    n_cmp++; if (out_lane_error !== 4'b0011) begin n_bad++; $display("FAIL beat_lane_error: got %0h expected 3", out_lane_error); end
    n_cmp++; if (out_error !== 1'b1) begin n_bad++; $display("FAIL beat_out_error: got %0h expected 1", out_error); end
    n_cmp++; if (sticky_lane_mask !== 4'b0011 || sticky_error !== 1'b1) begin n_bad++; $display("FAIL beat_sticky: got %0h/%0h expected 1/3", sticky_error, sticky_lane_mask); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_cmp++; if (sticky_lane_mask !== 4'b0000 || sticky_error !== 1'b0) begin n_bad++; $display("FAIL clear_sticky: got %0h/%0h expected 0/0", sticky_error, sticky_lane_mask); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL beat_drain: got %0h expected 0", out_valid); end
    // Code 1100 leaves only lane 0 wrong.
    in_valid = 1'b1; in_code = 4'b1100;
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_lane_error !== 4'b0001 || out_error !== 1'b1) begin n_bad++; $display("FAIL lane0_error: got %0h/%0h expected 1/1", out_lane_error, out_error); end
    n_cmp++; if (sticky_lane_mask !== 4'b0001) begin n_bad++; $display("FAIL lane0_mask: got %0h expected 1", sticky_lane_mask); end
    tick();
  endtask

  task automatic test_stall;
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA5A5A5A5; in_code = 4'b0000;
    tick();
    in_data = 32'h3C3C3C3C; in_code = 4'b0010;
    #1;
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL stall_in_ready: got %0h expected 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++; if (out_data !== 32'hA5A5A5A5 || out_lane_error !== 4'b0000 || out_valid !== 1'b1) begin n_bad++; $display("FAIL stall_hold: got %0h/%0h expected a5a5a5a5/0", out_data, out_lane_error); end
      n_cmp++; if (sticky_lane_mask !== 4'b0001) begin n_bad++; $display("FAIL stall_no_status: got %0h expected 1", sticky_lane_mask); end
    end
    out_ready = 1'b1;
    #1;
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL release_in_ready: got %0h expected 1", in_ready); end
    tick();
    in_valid = 1'b0;
    n_cmp++; if (out_data !== 32'h3C3C3C3C || out_lane_error !== 4'b0010) begin n_bad++; $display("FAIL release_beat: got %0h/%0h expected 3c3c3c3c/2", out_data, out_lane_error); end
    n_cmp++; if (sticky_lane_mask !== 4'b0011) begin n_bad++; $display("FAIL release_mask: got %0h expected 3", sticky_lane_mask); end
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL release_drain: got %0h expected 0", out_valid); end
  endtask

  task automatic test_clear;
    clear = 1'b1;
    tick();
    clear = 1'b0; in_valid = 1'b1; in_data = 32'h0; in_code = 4'b0001;
    tick();
    n_cmp++; if (sticky_lane_mask !== 4'b0001) begin n_bad++; $display("FAIL clear_pre_mask: got %0h expected 1", sticky_lane_mask); end
    clear = 1'b1; in_code = 4'b0100;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    n_cmp++; if (sticky_error !== 1'b1 || sticky_lane_mask !== 4'b0100) begin n_bad++; $display("FAIL clear_vs_error: got %0h/%0h expected 1/4", sticky_error, sticky_lane_mask); end
`ifdef PARITY_STREAM_CHECKER_COUNTER_EN
    n_cmp++; if (error_count !== 4'd1) begin n_bad++; $display("FAIL clear_vs_error_count: got %0d expected 1", error_count); end
`endif
    tick();
  endtask

`ifdef PARITY_STREAM_CHECKER_COUNTER_EN
  task automatic test_counter;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_cmp++; if (error_count !== 4'd0) begin n_bad++; $display("FAIL count_cleared: got %0d expected 0", error_count); end
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h0; in_code = 4'b0011;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (i == 14) begin n_cmp++; if (error_count !== 4'd14) begin n_bad++; $display("FAIL count_14: got %0d expected 14", error_count); end end
    end
    in_valid = 1'b0;
    n_cmp++; if (error_count !== 4'd15) begin n_bad++; $display("FAIL count_saturate: got %0d expected 15", error_count); end
    clear = 1'b1;
    tick();
    clear = 1'b0;
    n_cmp++; if (error_count !== 4'd0) begin n_bad++; $display("FAIL count_clear: got %0d expected 0", error_count); end
  endtask
`endif

  task automatic test_odd_and_reset;
    // Odd parity: 0xFF has XOR 0, so code 1 on every lane is correct.
    o_out_ready = 1'b1; o_in_valid = 1'b1; o_in_data = 32'h000000FF; o_in_code = 4'b1111;
    tick();
    n_cmp++; if (o_out_lane_error !== 4'b0000 || o_out_error !== 1'b0) begin n_bad++; $display("FAIL odd_clean: got %0h/%0h expected 0/0", o_out_lane_error, o_out_error); end
    o_in_code = 4'b1110;
    tick();
    o_in_valid = 1'b0;
    n_cmp++; if (o_out_lane_error !== 4'b0001 || o_out_error !== 1'b1) begin n_bad++; $display("FAIL odd_lane0: got %0h/%0h expected 1/1", o_out_lane_error, o_out_error); end
    // Hold a bad beat in the main instance, then reset mid-stall.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h0; in_code = 4'b0001;
    tick();
    n_cmp++; if (out_valid !== 1'b1 || sticky_error !== 1'b1) begin n_bad++; $display("FAIL pre_reset: got %0h/%0h expected 1/1", out_valid, sticky_error); end
    #2;
    resetn = 1'b0;
    #1;
    n_cmp++; if (out_valid !== 1'b0 || out_data !== 32'h0 || out_lane_error !== 4'h0) begin n_bad++; $display("FAIL async_reset_out: got %0h/%0h/%0h expected 0/0/0", out_valid, out_data, out_lane_error); end
    n_cmp++; if (sticky_error !== 1'b0 || sticky_lane_mask !== 4'h0 || error_count !== 4'h0) begin n_bad++; $display("FAIL async_reset_status: got %0h/%0h/%0h expected 0/0/0", sticky_error, sticky_lane_mask, error_count); end
    n_cmp++; if (in_ready !== 1'b1 || o_sticky_error !== 1'b0) begin n_bad++; $display("FAIL async_reset_ready: got %0h/%0h expected 1/0", in_ready, o_sticky_error); end
    in_valid = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL no_replay: got %0h expected 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_single_beat();
    test_stall();
    test_clear();
`ifdef PARITY_STREAM_CHECKER_COUNTER_EN
    test_counter();
`endif
    test_odd_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
